gray_sweep_controller: RTL
==========================

// Module: gray_sweep_controller
// PURPOSE
//  Sequences a WIDTH-bit Gray-code generator.
//  - Holds a binary count and converts it to registered Gray code (g[i] = b[i+1]^b[i], MSB passes through).
//  - Sweeps all 2^WIDTH codes, up or down, either free-running at a programmed rate or one code per step request.
//  - Drives position-encoder stimulus and single-bit-change bus test patterns in the Gray-code datapath.
// PARAMETERS
//  WIDTH   3   code width in bits (>=2)
//  DIV     4   clocks per code in free-run mode (>=1; 1 = new code every cycle)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      reset, synchronous, active-low
//  start   in   1      begin sweep; honoured only in IDLE
//  stop    in   1      abort sweep; highest priority
//  dir     in   1      0 = count up, 1 = count down; sampled with start
//  mode    in   1      0 = free-run, 1 = single-step; sampled with start
//  step    in   1      advance one code (step mode only)
//  gray    out  WIDTH  current Gray code, registered
//  valid   out  1      1-cycle pulse when gray takes a new code
//  busy    out  1      high from cycle after start until sweep ends or aborts
//  done    out  1      1-cycle pulse after last code of a completed sweep
//  err     out  1      sticky Hamming-distance error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, bin=0, cnt=0, gray=0, valid=0, busy=0, done=0, err=0.
//  - States: IDLE, RUN, STEP, FIN.
//  - IDLE:
//    - start=1 & stop=0 -> bin = dir ? 2^WIDTH-1 : 0; latch dir and mode; gray=bin2gray(bin) and valid=1 next cycle (latency 1).
//    - Next state is RUN (mode=0) or STEP (mode=1); busy=1.
//  - RUN:
//    - cnt counts 0..DIV-1; at cnt==DIV-1, bin +/- 1, gray updates, valid pulses, cnt=0.
//    - Each code is therefore held exactly DIV cycles.
//  - STEP:
//    - step=1 in a cycle -> bin +/- 1, gray and valid update next cycle.
//    - step held high advances once per cycle; step=0 holds.
//  - Terminal code: bin == 2^WIDTH-1 (up) or 0 (down).
//    - Advance request on terminal code -> no bin change, no valid; state=FIN.
//  - FIN: done=1 for one cycle, busy=0, next state IDLE; gray holds the last code.
//  - Full sweep presents exactly 2^WIDTH valid pulses.
//    - Example, WIDTH=3 up: 000,001,011,010,110,111,101,100.
//  - stop=1 in RUN/STEP: next cycle state=IDLE, busy=0, no done, no valid; gray holds; cnt=0.
//  - Simultaneous events:
//    - stop beats start, step and the DIV timer.
//    - start while busy is ignored.
//    - step in mode 0 is ignored.
//  - bin arithmetic is modulo 2^WIDTH; wrap never occurs inside a sweep because the terminal check precedes the increment.
//  - Reset mid-sweep: immediate return to reset values on that edge; no done.
//  - cnt width = clog2(DIV)+1.
// CONFIGURATION
//  GRAY_SWEEP_CHECK_EN
//  - Defined:
//    - Keep the previous gray value; on each valid, compare it with the new gray.
//    - Consecutive codes (the first code of a sweep is exempt) must differ in exactly one bit; otherwise err=1.
//    - err is sticky until reset or the next accepted start.
//  - Undefined: no checker logic; err tied to 0.
// TESTING
//  1. Reset: rst_n=0 for 2 clk -> gray=000, valid=busy=done=err=0.
//  2. WIDTH=3, DIV=4, mode=0, dir=0, start pulse:
//     - gray=000 with valid 1 cycle later.
//     - Then 001,011,010,110,111,101,100, each held 4 cycles.
//     - done pulses 4 cycles after 100 appears; 8 valids total.
//  3. mode=1, dir=1, start, then step pulses:
//     - start gives 100; 7 steps give 101,111,110,010,011,001,000.
//     - 8th step -> done, no valid; gray stays 000.
//  4. Free-run up; stop=1 when gray=010:
//     - busy=0 next cycle, gray holds 010, no done.
//     - start same cycle as stop in IDLE -> ignored.
//  5. start pulsed again while busy -> sequence unaffected.
//     rst_n=0 mid-sweep -> all outputs 0 next edge.
//  6. With GRAY_SWEEP_CHECK_EN:
//     - Clean sweep -> err=0.
//     - Force the gray register (bench force) to a 2-bit jump -> err=1 on that valid; cleared by the next start.

Source files
------------

// File: rtl/gray_sweep_controller_if.sv
// Control/status bundle between a sweep sequencer and the Gray-code sweep controller.
// Latency: none (wires only); the controller registers every output it drives.
// Backpressure: none; start/stop/step are level requests sampled every clock.
interface gray_sweep_controller_if #(
    parameter int WIDTH = 3
);
    logic             i_start;
    logic             i_stop;
    logic             i_dir;
    logic             i_mode;
    logic             i_step;
    logic [WIDTH-1:0] o_gray;
    logic             o_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    // Sequencer side: issues requests, observes codes and status.
    modport master (
        output i_start, i_stop, i_dir, i_mode, i_step,
        input  o_gray, o_valid, o_busy, o_done, o_err
    );

    // Controller side.
    modport slave (
        input  i_start, i_stop, i_dir, i_mode, i_step,
        output o_gray, o_valid, o_busy, o_done, o_err
    );
endinterface

// File: rtl/gray_sweep_controller.sv
// Sweeps all 2^WIDTH Gray codes up/down, free-running every DIV clocks or one code per step.
// Latency: start/step/timer -> new registered gray + valid on the next clock edge.
// Backpressure: none; stop aborts immediately, optional checker via GRAY_SWEEP_CHECK_EN.
module gray_sweep_controller #(
    parameter int WIDTH = 3,
    parameter int DIV   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    gray_sweep_controller_if.slave io_bus
);
    localparam int               CW       = $clog2(DIV) + 1;
    localparam logic [WIDTH-1:0] BIN_MAX  = '1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             w_adv;
    logic             w_term;
    logic [WIDTH-1:0] w_bin_step;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Terminal code is checked before any increment, so bin never wraps mid-sweep.
    assign w_term     = r_dir ? (r_bin == '0) : (r_bin == BIN_MAX);
    assign w_bin_step = r_dir ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));

    // Next-state and datapath decode; stop outranks start, step and the rate timer.
    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = r_cnt;
        w_gray_nxt  = r_gray;
        w_valid_nxt = 1'b0;
        w_dir_nxt   = r_dir;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_start && !io_bus.i_stop) begin
                    w_dir_nxt   = io_bus.i_dir;
                    w_bin_nxt   = io_bus.i_dir ? BIN_MAX : '0;
                    w_gray_nxt  = io_bus.i_dir ? bin2gray(BIN_MAX) : '0;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = io_bus.i_mode ? S_STEP : S_RUN;
                end
            end
            S_RUN: begin
                if (io_bus.i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_adv     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STEP: begin
                if (io_bus.i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_adv = io_bus.i_step;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_adv) begin
            if (w_term) begin
                w_state_nxt = S_FIN;
            end else begin
                w_bin_nxt   = w_bin_step;
                w_gray_nxt  = bin2gray(w_bin_step);
                w_valid_nxt = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_gray  <= '0;
            r_valid <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gray  <= w_gray_nxt;
            r_valid <= w_valid_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign io_bus.o_gray  = r_gray;
    assign io_bus.o_valid = r_valid;
    assign io_bus.o_busy  = (r_state == S_RUN) || (r_state == S_STEP);
    assign io_bus.o_done  = (r_state == S_FIN);

`ifdef GRAY_SWEEP_CHECK_EN
    logic             r_err;
    logic             w_start_acc;
    logic [WIDTH-1:0] w_diff;
    logic             w_bad;

    // The first code of a sweep comes from an accepted start and is exempt.
    assign w_start_acc = (r_state == S_IDLE) && io_bus.i_start && !io_bus.i_stop;
    assign w_diff      = w_gray_nxt ^ r_gray;
    assign w_bad       = w_valid_nxt && !w_start_acc &&
                         ((w_diff == '0) || ((w_diff & (w_diff - WIDTH'(1))) != '0));

    // Sticky single-bit-change error, cleared by reset or an accepted start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign io_bus.o_err = r_err;
`else
    assign io_bus.o_err = 1'b0;
`endif

endmodule
